// File: rtl/seq_multiplier_64.sv
// Iterative shift-add 32x32 -> 64 multiplier (signed/unsigned) for the HI/LO path.
// Optional build macro MULT_EARLY_TERM_EN ends RUN once the remaining multiplier is zero.
module seq_multiplier_64 #(
    parameter int WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Signed,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   mcand;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_sum;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]   cnt;
    logic            neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic            last_step;

    // Magnitudes are held unsigned, so -2^31 becomes 0x8000_0000 without overflow.
    always_comb begin
        mag_a = (Signed && A[WIDTH-1]) ? -A : A;
        mag_b = (Signed && B[WIDTH-1]) ? -B : B;
    end

    always_comb begin
        acc_sum = mplier[0] ? (acc + mcand) : acc;
    end

`ifdef MULT_EARLY_TERM_EN
    // Stop as soon as no set multiplier bits remain after this step.
    always_comb begin
        last_step = (mplier[WIDTH-1:1] == '0) || (cnt == CW'(WIDTH - 1));
    end
`else
    always_comb begin
        last_step = (cnt == CW'(WIDTH - 1));
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Busy comes straight from the state register; Start never reaches it combinationally.
    assign Busy = (state != IDLE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            Product <= '0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        acc    <= '0;
                        cnt    <= '0;
                        neg    <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                    end
                end
                RUN: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                FIX: begin
                    Product <= neg ? -acc : acc;
                    Done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_64.sv
// Self-checking bench for seq_multiplier_64: cycle-level behavioural model, per-cycle
// compare of Busy/Done/Product, directed cases with literal results, random operations.
module tb_seq_multiplier_64;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Signed;
    logic [31:0] A, B;
    logic        Busy, Done;
    logic [63:0] Product;

    seq_multiplier_64 #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Signed(Signed),
        .A(A), .B(B), .Busy(Busy), .Done(Done), .Product(Product)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    bit checking = 0;

    // Model state
    int          remaining = 0;
    logic [63:0] pend_val = '0;
    logic [63:0] exp_prod = '0;
    bit          exp_done = 0;
    int          cyc = 0;
    int          t_start = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        if (s) begin
            ea = {{32{a[31]}}, a};
            eb = {{32{b[31]}}, b};
        end else begin
            ea = {32'h0, a};
            eb = {32'h0, b};
        end
        return ea * eb;
    endfunction

    function automatic int lat_of(input bit s, input logic [31:0] b);
`ifdef MULT_EARLY_TERM_EN
        logic [31:0] mag;
        int run;
        mag = (s && b[31]) ? -b : b;
        run = 1;
        for (int i = 0; i < 32; i++)
            if (mag[i]) run = i + 1;
        return run + 1;
`else
        return 33;
`endif
    endfunction

    // Model: an accepted request completes exactly lat_of() edges later; Start ignored while busy.
    always @(posedge Clk) begin
        cyc++;
        if (Reset) begin
            remaining = 0;
            exp_prod  = '0;
            exp_done  = 0;
        end else begin
            exp_done = 0;
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    exp_prod = pend_val;
                    exp_done = 1;
                end
            end else if (Start) begin
                pend_val  = ref_mul(Signed, A, B);
                remaining = lat_of(Signed, B);
            end
        end
    end

    always @(negedge Clk) begin
        if (checking) begin
            chk("busy",    {63'h0, Busy}, {63'h0, remaining > 0});
            chk("done",    {63'h0, Done}, {63'h0, exp_done});
            chk("product", Product, exp_prod);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic launch(input bit s, input logic [31:0] a, input logic [31:0] b, input bit rec);
        Start = 1'b1; Signed = s; A = a; B = b;
        tick();
        if (rec) t_start = cyc;
        Start = 1'b0; Signed = $urandom_range(0, 1); A = $urandom; B = $urandom;
    endtask

    task automatic wait_done(input string name, input logic [63:0] req, input int lat);
        int n;
        n = 0;
        while (!Done && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_seen"},    {63'h0, Done}, 64'h1);
        chk({name, "_latency"}, 64'(cyc - t_start), 64'(lat));
        chk({name, "_value"},   Product, req);
    endtask

    logic [31:0] ra, rb;
    bit          rs;

    initial begin
        Reset = 1'b1; Start = 1'b0; Signed = 1'b0; A = '0; B = '0;
        tick();
        checking = 1;
        tick();
        Reset = 1'b0;
        chk("reset_busy", {63'h0, Busy}, 64'h0);
        chk("reset_done", {63'h0, Done}, 64'h0);
        chk("reset_product", Product, 64'h0);

        // Model pins
        chk("model_umax", ref_mul(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        chk("model_neg21", ref_mul(1, 32'hFFFF_FFFD, 32'h7), 64'hFFFF_FFFF_FFFF_FFEB);
        tick();

        // Unsigned max, with Busy held for the full 33 cycles
        launch(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        begin
            int bc;
            bc = 1;
            while (Busy && bc < 100) begin tick(); if (Busy) bc++; end
            chk("umax_busy_cycles", 64'(bc), 64'(lat_of(0, 32'hFFFF_FFFF)));
        end
        chk("umax_done", {63'h0, Done}, 64'h1);
        chk("umax_value", Product, 64'hFFFF_FFFE_0000_0001);
        tick();

        launch(1, 32'hFFFF_FFFD, 32'h0000_0007, 1);
        wait_done("neg3x7", 64'hFFFF_FFFF_FFFF_FFEB, lat_of(1, 32'h7));
        tick();
        launch(1, 32'h8000_0000, 32'h8000_0000, 1);
        wait_done("minxmin", 64'h4000_0000_0000_0000, lat_of(1, 32'h8000_0000));
        tick();

        // Start while busy is ignored
        launch(0, 32'd6, 32'd7, 1);
        repeat (8) tick();
        launch(0, 32'd2, 32'd2, 0);
        wait_done("busy_ignore", 64'd42, lat_of(0, 32'd7));
        repeat (40) tick();

        // Back-to-back: second Start in the Done cycle
        launch(0, 32'd3, 32'd4, 1);
        wait_done("b2b_first", 64'd12, lat_of(0, 32'd4));
        launch(0, 32'd5, 32'd5, 1);
        begin
            int held;
            held = 1;
            while (!Done && cyc - t_start < 100) begin
                if (Product !== 64'd12) held = 0;
                tick();
            end
            chk("b2b_hold12", 64'(held), 64'd1);
        end
        wait_done("b2b_second", 64'd25, lat_of(0, 32'd5));
        tick();

        // Reset in the middle of RUN
        launch(0, 32'd1234, 32'hFFFF_0001, 1);
        repeat (14) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("midreset_busy", {63'h0, Busy}, 64'h0);
        chk("midreset_product", Product, 64'h0);
        begin
            int seen;
            seen = 0;
            repeat (40) begin tick(); if (Done) seen = 1; end
            chk("midreset_no_done", 64'(seen), 64'h0);
        end
        launch(0, 32'd9, 32'd9, 1);
        wait_done("after_reset", 64'd81, lat_of(0, 32'd9));
        tick();

`ifdef MULT_EARLY_TERM_EN
        launch(0, 32'd123, 32'd0, 1);
        wait_done("et_b0", 64'd0, 2);
        tick();
        launch(0, 32'd1, 32'h100, 1);
        wait_done("et_b256", 64'd256, 10);
        tick();
`endif

        // Random operations; sometimes back-to-back, sometimes with idle gaps
        for (int i = 0; i < 30; i++) begin
            rs = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: ra = 32'h8000_0000;
                1: ra = $urandom_range(0, 15);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: rb = 32'hFFFF_FFFF;
                1: rb = 32'd1 << $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            launch(rs, ra, rb, 1);
            wait_done("rand", ref_mul(rs, ra, rb), lat_of(rs, rb));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) tick();
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_multiplier_64.md
# seq_multiplier_64

Iterative 32x32 -> 64-bit multiplier for the HI/LO path of the pipelined MIPS core. It executes MULT/MULTU, and the multiply half of MADD/MSUB, over multiple clocks. Its registered 64-bit product feeds the 64-bit add/subtract stage that accumulates into HI/LO. The EX stage starts it and stalls on `Busy` until `Done`.

## Interface
- `WIDTH`, 32, operand width; product is 2*`WIDTH` bits. Only 32 is verified.
- `Clk`  in  1  clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  request a multiply; sampled only in IDLE.
- `Signed`  in  1  1 = two's-complement operands (MULT); 0 = unsigned (MULTU); captured with `Start`.
- `A`  in  `WIDTH`  multiplicand; captured with `Start`.
- `B`  in  `WIDTH`  multiplier; captured with `Start`.
- `Busy`  out  1  high while a multiply is in flight (RUN or FIX).
- `Done`  out  1  one-cycle pulse; `Product` is valid from this cycle.
- `Product`  out  2*`WIDTH`  registered result; holds until the next completion.

## Operation
- States:
  - IDLE: waits for `Start`.
  - RUN: one shift-add step per clock.
  - FIX: applies the sign to the result.
- Capture (IDLE and `Start`=1):
  - Magnitudes: if `Signed` and the operand MSB is set, store its two's-complement negation. Otherwise store the operand as-is.
  - For -2^31 the magnitude 0x8000_0000 is held unsigned, so no overflow occurs.
  - Store `neg` = `Signed` & (A[31] ^ B[31]).
  - Clear the 64-bit accumulator and the 6-bit step counter; go to RUN.
- RUN, each step:
  - If the multiplier LSB is 1, add the multiplicand (zero-extended to 64 bits, left-shifted by the step count) to the accumulator. Equivalently, shift the multiplicand left once per step.
  - Shift the multiplier right once; increment the counter.
  - After 32 steps, go to FIX.
- FIX:
  - `Product` <= `neg` ? -acc : acc, computed mod 2^64.
  - Pulse `Done`; go to IDLE.
- `Start` is ignored while `Busy`=1. No queuing; the operands are not re-sampled.
- `Start` asserted during the `Done` cycle is accepted, because the block is already in IDLE then.
- `Signed`, `A` and `B` are don't-care outside the capture cycle.
- `Reset` at any time, including mid-RUN:
  - state = IDLE, `Busy`=0, `Done`=0, `Product`=0, internal registers = 0.
  - The in-flight operation is discarded and `Done` never fires for it.
- Reset values: `Busy`=0, `Done`=0, `Product`=64'h0.

## Timing
- Start accepted at edge k; `Busy`=1 from edge k through edge k+33.
- RUN covers edges k+1..k+32. FIX is the cycle after edge k+32.
- At edge k+33: `Product` is updated, `Done`=1 for exactly one cycle, `Busy`=0.
- Latency is 33 clocks from the accepting edge to valid `Product`/`Done`.
- Back-to-back operation: `Start` in the `Done` cycle yields the next `Done` 33 clocks later, giving a throughput of one multiply per 33 clocks.
- `Busy` is registered, with no combinational path from `Start`.
- `Product` changes only on a `Done` edge or on reset.

## Configuration
- `MULT_EARLY_TERM_EN` defined:
  - In RUN, if the remaining shifted multiplier is 0 after a step, go to FIX immediately.
  - RUN length = max(1, index of the highest set bit of |B| + 1).
  - Latency = RUN length + 1. Examples: B=0 or B=1 gives 2 clocks; |B|=2^31 gives 33.
  - The result is identical to the non-early-termination result.
- Not defined: RUN always takes 32 steps and latency is fixed at 33 clocks. This is the default, and the hazard unit depends on it unless the macro is set.

## Test plan
- Unsigned: `Signed`=0, A=0xFFFF_FFFF, B=0xFFFF_FFFF, pulse `Start` -> `Done` exactly 33 clocks later with `Product`=0xFFFF_FFFE_0000_0001; `Busy` high for 33 cycles.
- Signed: `Signed`=1, A=0xFFFF_FFFD (-3), B=0x0000_0007 -> `Product`=0xFFFF_FFFF_FFFF_FFEB (-21). Then A=0x8000_0000, B=0x8000_0000 -> `Product`=0x4000_0000_0000_0000.
- Start while busy: start 6x7; pulse `Start` with 2x2 at clock 10 -> single `Done` with `Product`=42; the second request is ignored.
- Back-to-back: assert `Start` with 5x5 in the `Done` cycle of 3x4 -> `Product`=12 with `Done`, then `Product`=25 and `Done` 33 clocks later; 12 holds in between.
- Reset mid-operation: `Reset` at clock 15 of a RUN -> next cycle `Busy`=0, `Product`=0, and no `Done` ever appears. A new 9x9 afterwards -> 81 at the normal latency.
- With `MULT_EARLY_TERM_EN`: A=123, B=0 -> `Product`=0 after 2 clocks. A=1, B=0x0000_0100 -> `Product`=256 after 10 clocks. Random signed/unsigned pairs match the reference model at any latency.
